// File: rtl/data_mem_pipe_if.sv
// data_mem_pipe_if -- request/response bus between a processor pipeline and
// the data_mem_pipe memory block.
//   master (processor side): drives req_valid, req_wr, req_addr, req_wdata,
//                            halt; observes req_ready, rsp_valid, rsp_rdata,
//                            rsp_err, stall.
//   slave  (memory side)   : the mirror image.
interface data_mem_pipe_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              halt;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              stall;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, halt,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, halt,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface

// File: rtl/data_mem_pipe.sv
// data_mem_pipe -- fixed-latency word-addressed data memory for a processor
// pipeline. One access in flight at a time; the response strobe appears a
// fixed LATENCY edges after acceptance (the accepting edge counts as the
// first), and a new request may be accepted in the response cycle.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : data_mem_pipe_if.slave (request, halt, ready, response, stall)
// Byte addresses are converted to word indices with bit 0 flagging a
// misaligned access; upper address bits beyond the array wrap.
module data_mem_pipe #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_pipe_if.slave bus
);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;

  // Request captured at the accepting edge.
  logic                  cap_wr_reg;
  logic                  cap_mis_reg;
  logic [DEPTH_LOG2-1:0] cap_idx_reg;
  logic [DATA_W-1:0]     cap_wdata_reg;

  logic                  req_ready;
  logic                  accept;
  logic                  enter_resp;
  logic                  commit;

  // Request that is completing on the current edge. With LATENCY=1 the
  // completing request is the one being accepted, so it has not reached the
  // capture registers yet.
  logic                  sel_wr;
  logic                  sel_mis;
  logic [DEPTH_LOG2-1:0] sel_idx;
  logic [DATA_W-1:0]     sel_wdata;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DATA_W-1:0]     rd_word;

  // Address bits above the word index are deliberately ignored (wrap).
  logic                  addr_unused;
  assign addr_unused = ^bus.req_addr[ADDR_W-1:DEPTH_LOG2+1];

  assign req_ready = ((state_reg == IDLE) || (state_reg == RESP)) && !bus.halt;
  assign accept    = bus.req_valid && req_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE, RESP: begin
        state_next = IDLE;
        if (accept) begin
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - 1'b1;
        // Counter reaches 0 on this edge: the access completes now.
        if (cnt_reg == CNT_W'(1)) begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cap_wr_reg    <= 1'b0;
      cap_mis_reg   <= 1'b0;
      cap_idx_reg   <= '0;
      cap_wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        cap_wr_reg    <= bus.req_wr;
        cap_mis_reg   <= bus.req_addr[0];
        cap_idx_reg   <= bus.req_addr[DEPTH_LOG2:1];
        cap_wdata_reg <= bus.req_wdata;
      end
    end
  end

  assign sel_wr    = accept ? bus.req_wr                  : cap_wr_reg;
  assign sel_mis   = accept ? bus.req_addr[0]             : cap_mis_reg;
  assign sel_idx   = accept ? bus.req_addr[DEPTH_LOG2:1]  : cap_idx_reg;
  assign sel_wdata = accept ? bus.req_wdata               : cap_wdata_reg;

  assign enter_resp = (state_next == RESP);
  // rst gates the commit so an edge arriving while reset is held cannot
  // write a half-finished access into the array.
  assign commit = enter_resp && rst && sel_wr && !sel_mis;

  // Array has no reset; read is registered every edge so the value sampled
  // on the edge entering RESP is what the response presents.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[sel_idx] <= sel_wdata;
    end
    rd_word <= mem[sel_idx];
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_err   = (state_reg == RESP) && cap_mis_reg;
  assign bus.rsp_rdata = ((state_reg == RESP) && !cap_wr_reg && !cap_mis_reg)
                         ? rd_word : '0;
  assign bus.stall     = (state_reg == BUSY) || (bus.req_valid && !req_ready);
endmodule

// File: tb/tb_data_mem_pipe.sv
module tb_data_mem_pipe;
  localparam int LAT   = 2;
  localparam int LAT3  = 3;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  // Reference memory: word index -> last value written (absent = unknown).
  logic [15:0] model_mem [int];

  logic [15:0] b2b_addr  [4] = '{16'h0020, 16'h0022, 16'h0020, 16'h0022};
  logic        b2b_wr    [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic [15:0] b2b_wdata [4] = '{16'hA5A5, 16'h5A5A, 16'h0000, 16'h0000};
  logic [15:0] b2b_exp   [4] = '{16'h0000, 16'h0000, 16'hA5A5, 16'h5A5A};

  data_mem_pipe_if #(.DATA_W(16), .ADDR_W(16)) bus ();
  data_mem_pipe_if #(.DATA_W(16), .ADDR_W(16)) bus3 ();

  data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  data_mem_pipe #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(LAT3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access on the LATENCY=2 instance, optionally preceded by
  // halt_cycles cycles of a halted request.
  task automatic do_req(input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input int halt_cycles);
    int          idx;
    logic        mis;
    logic        known;
    logic [15:0] exp_rd;
    int          n;
    logic        got;
    idx    = (int'(addr) / 2) % DEPTH;
    mis    = (int'(addr) % 2) != 0;
    known  = 1'b1;
    exp_rd = 16'h0000;
    if (!wr && !mis) begin
      known = model_mem.exists(idx);
      if (known) exp_rd = model_mem[idx];
    end
    for (int h = 0; h < halt_cycles; h++) begin
      @(negedge clk);
      bus.halt = 1'b1; bus.req_valid = 1'b1;
      bus.req_wr = wr; bus.req_addr = addr; bus.req_wdata = wdata;
      #1;
      chk("halt_ready", 32'(bus.req_ready), 0);
      chk("halt_stall", 32'(bus.stall), 1);
      chk("halt_rsp_valid", 32'(bus.rsp_valid), 0);
    end
    @(negedge clk);
    bus.halt = 1'b0; bus.req_valid = 1'b1;
    bus.req_wr = wr; bus.req_addr = addr; bus.req_wdata = wdata;
    #1;
    chk("issue_ready", 32'(bus.req_ready), 1);
    chk("issue_stall", 32'(bus.stall), 0);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      // Request fields scrambled after acceptance; the access must not care.
      bus.req_valid = 1'b0;
      bus.req_wr    = 1'($urandom);
      bus.req_addr  = 16'($urandom);
      bus.req_wdata = 16'($urandom);
      bus.halt      = 1'($urandom);
      #1;
      if (bus.rsp_valid === 1'b1) got = 1'b1;
      else chk("busy_stall", 32'(bus.stall), 1);
    end
    chk("rsp_latency", 32'(n), 32'(LAT));
    if (got) begin
      chk("rsp_err", 32'(bus.rsp_err), 32'(mis));
      chk("rsp_stall", 32'(bus.stall), 0);
      if (known) chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
    end
    if (wr && !mis) model_mem[idx] = wdata;
    $display("txn %s addr=%h wdata=%h -> valid=%0b err=%0b rdata=%h lat=%0d",
             wr ? "WR" : "RD", addr, wdata, got, bus.rsp_err, bus.rsp_rdata, n);
    bus.halt = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.halt = 1'b0;
    bus3.req_valid = 1'b0; bus3.req_wr = 1'b0; bus3.req_addr = '0; bus3.req_wdata = '0; bus3.halt = 1'b0;

    // Reset state.
    #2 rst = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_ready", 32'(bus.req_ready), 1);
    chk("rst_stall", 32'(bus.stall), 0);
    bus.halt = 1'b1;
    #1;
    chk("rst_ready_halt", 32'(bus.req_ready), 0);
    bus.halt = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Basic write then read back.
    do_req(1'b1, 16'h0010, 16'hBEEF, 0);
    do_req(1'b0, 16'h0010, 16'h0000, 0);
    // Misaligned write leaves memory untouched.
    do_req(1'b1, 16'h0011, 16'h1234, 0);
    do_req(1'b0, 16'h0010, 16'h0000, 0);
    // Address wrap.
    do_req(1'b1, 16'h0202, 16'h00AA, 0);
    do_req(1'b0, 16'h0002, 16'h0000, 0);
    // Halted request held for 5 cycles, then accepted.
    do_req(1'b0, 16'h0002, 16'h0000, 5);

    // Reset during BUSY aborts a pending write.
    do_req(1'b1, 16'h0040, 16'h1111, 0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_addr = 16'h0040; bus.req_wdata = 16'h5555;
    #1;
    chk("abort_issue_ready", 32'(bus.req_ready), 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1;
    chk("abort_busy_stall", 32'(bus.stall), 1);
    #1 rst = 1'b0;
    #1;
    chk("abort_rst_stall", 32'(bus.stall), 0);
    chk("abort_rst_valid", 32'(bus.rsp_valid), 0);
    chk("abort_rst_rdata", 32'(bus.rsp_rdata), 0);
    chk("abort_rst_err", 32'(bus.rsp_err), 0);
    chk("abort_rst_ready", 32'(bus.req_ready), 1);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("abort_hold_valid", 32'(bus.rsp_valid), 0);
      chk("abort_hold_stall", 32'(bus.stall), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("abort_after_valid", 32'(bus.rsp_valid), 0);
    end
    do_req(1'b0, 16'h0040, 16'h0000, 0);

    // Randomized accesses over a small aliased window.
    for (int t = 0; t < 40; t++) begin
      logic [15:0] a;
      a = {7'($urandom), 5'b00011, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0)};
      do_req(1'($urandom), a, 16'($urandom), int'($urandom_range(0, 2)));
    end

    // Back-to-back accesses on the LATENCY=3 instance with req_valid held.
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c % 3 == 0) begin
        if (c / 3 < 4) begin
          bus3.req_valid = 1'b1;
          bus3.req_wr    = b2b_wr[c / 3];
          bus3.req_addr  = b2b_addr[c / 3];
          bus3.req_wdata = b2b_wdata[c / 3];
        end else begin
          bus3.req_valid = 1'b0;
        end
      end else begin
        bus3.req_wr    = 1'($urandom);
        bus3.req_addr  = 16'($urandom);
        bus3.req_wdata = 16'($urandom);
      end
      #1;
      if (c % 3 == 0) begin
        chk("b2b_ready", 32'(bus3.req_ready), 1);
        chk("b2b_stall_resp", 32'(bus3.stall), 0);
        chk("b2b_rsp_valid", 32'(bus3.rsp_valid), 32'(c > 0));
        if (c > 0) begin
          chk("b2b_rsp_rdata", 32'(bus3.rsp_rdata), 32'(b2b_exp[c / 3 - 1]));
          chk("b2b_rsp_err", 32'(bus3.rsp_err), 0);
          $display("b2b txn %0d addr=%h -> valid=%0b err=%0b rdata=%h", c / 3 - 1,
                   b2b_addr[c / 3 - 1], bus3.rsp_valid, bus3.rsp_err, bus3.rsp_rdata);
        end
      end else begin
        chk("b2b_busy_ready", 32'(bus3.req_ready), 0);
        chk("b2b_busy_stall", 32'(bus3.stall), 1);
        chk("b2b_busy_valid", 32'(bus3.rsp_valid), 0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/data_mem_pipe.md
DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits.
REQ-002 Parameter ADDR_W, default 16, byte-address width in bits.
REQ-003 Parameter DEPTH_LOG2, default 8, log2 of the number of DATA_W words in the internal array.
REQ-004 Parameter LATENCY, default 2, legal range 1..8, number of clock edges from request acceptance to response.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately, regardless of clk.
REQ-007 req_valid  input  1  access request present.
REQ-008 req_wr  input  1  1=write, 0=read; sampled with req_valid.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 halt  input  1  blocks new acceptances while high.
REQ-012 req_ready  output  1  block can accept a request this cycle.
REQ-013 rsp_valid  output  1  one-cycle response strobe.
REQ-014 rsp_rdata  output  DATA_W  read data; valid only with rsp_valid.
REQ-015 rsp_err  output  1  misaligned access flag; valid only with rsp_valid.
REQ-016 stall  output  1  pipeline stall request to the processor.

Function
REQ-017 FSM states: IDLE, BUSY, RESP; reset state IDLE.
REQ-018 req_ready = (state==IDLE or state==RESP) and halt==0.
REQ-019 Acceptance: rising edge with req_valid=1 and req_ready=1; req_wr, req_addr, req_wdata captured at that edge; a down-counter loads LATENCY-1.
REQ-020 On acceptance: LATENCY=1 -> next state RESP; LATENCY>1 -> BUSY.
REQ-021 BUSY: counter decrements by 1 per edge; transition to RESP on the edge where the counter reaches 0 (exactly LATENCY edges after acceptance, inclusive of that edge count).
REQ-022 RESP: rsp_valid=1 for exactly one cycle; next state IDLE unless a new request is accepted in the same cycle, in which case it follows REQ-020 (back-to-back, no idle bubble).
REQ-023 Word index = req_addr[DEPTH_LOG2:1]; address bits above DEPTH_LOG2 ignored (wrap modulo 2^DEPTH_LOG2 words).
REQ-024 Misaligned = req_addr[0]==1; such requests complete with normal timing, rsp_err=1, rsp_rdata=0, no array write.
REQ-025 Aligned write commits to the array on the edge entering RESP; rsp_rdata=0, rsp_err=0 for writes.
REQ-026 Aligned read: rsp_rdata = array word at the captured index as of the edge entering RESP (includes a write committed by the immediately preceding request).
REQ-027 stall = 1 whenever state==BUSY, or req_valid==1 and req_ready==0; else 0.
REQ-028 halt asserted during BUSY/RESP does not abort the in-flight access; it only blocks the next acceptance.
REQ-029 req_* inputs are ignored outside an acceptance edge; changes mid-access have no effect.
REQ-030 Array contents are not reset and are uninitialised after power-up.

Reset
REQ-031 rst=0: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, captured request cleared; req_ready=!halt, stall=0 (with req_valid=0).
REQ-032 Reset during BUSY aborts the access; a pending write is not committed and no response is produced.
REQ-033 First acceptance possible on the first rising edge after rst returns to 1.

Verification
REQ-034 LATENCY=2: write 0xBEEF to 0x0010, then read 0x0010 -> write response 2 edges after accept; read returns rsp_rdata=0xBEEF, rsp_err=0.
REQ-035 LATENCY=3, req_valid held high with alternating addresses -> one acceptance every 3 edges, rsp_valid and next acceptance in the same cycle, stall=1 only in BUSY.
REQ-036 Write 0x1234 to 0x0011 -> rsp_err=1, rsp_rdata=0; subsequent read of 0x0010 returns prior contents unchanged.
REQ-037 DEPTH_LOG2=8: write 0x00AA to 0x0202, read 0x0002 -> rsp_rdata=0x00AA (wrap).
REQ-038 Write accepted, rst pulsed low in BUSY -> no rsp_valid, target word unchanged on later read; outputs at reset values while rst=0.
REQ-039 halt=1 with req_valid=1 in IDLE for 5 cycles -> req_ready=0, stall=1, no acceptance; halt=0 -> accepted next edge.
